// File: rtl/inst_mem_if.sv
// Fetch and program-loader signals between inst_mem (slave) and the core/loader side (master).
interface inst_mem_if #(
    parameter int ADDR_W = 10
);
    logic              ce_i;
    logic [31:0]       addr_i;
    logic [31:0]       inst_o;
    logic              ld_start_i;
    logic [ADDR_W:0]   ld_words_i;
    logic              ld_valid_i;
    logic [7:0]        ld_byte_i;
    logic              ld_ready_o;
    logic              ld_done_o;
    logic              cpu_hold_o;

    modport master (
        output ce_i, addr_i, ld_start_i, ld_words_i, ld_valid_i, ld_byte_i,
        input  inst_o, ld_ready_o, ld_done_o, cpu_hold_o
    );

    modport slave (
        input  ce_i, addr_i, ld_start_i, ld_words_i, ld_valid_i, ld_byte_i,
        output inst_o, ld_ready_o, ld_done_o, cpu_hold_o
    );
endinterface

// File: rtl/inst_mem.sv
// Instruction memory with combinational fetch and a byte-serial program loader.
module inst_mem #(
    parameter int ADDR_W = 10
) (
    input logic        clk,
    input logic        rst,
    inst_mem_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [23:0]       asm_q, asm_d;

    logic [31:0]       mem [DEPTH];

    logic              restart;
    logic              take;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic              unused_addr;

    // A start in LOAD preempts any byte offered in the same cycle.
    assign restart = bus.ld_start_i && (state_q != S_DONE);
    assign take    = bus.ld_valid_i && (state_q == S_LOAD) && !restart;
    assign wr_en   = take && (bcnt_q == 2'd3);
    assign wr_data = {bus.ld_byte_i, asm_q};

    assign unused_addr = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (restart) begin
                    state_d = (bus.ld_words_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (restart) begin
                    state_d = (bus.ld_words_i == '0) ? S_DONE : S_LOAD;
                end else if (wr_en && (rem_q == (ADDR_W+1)'(1))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ld_ready_o = (state_q == S_LOAD);
        bus.ld_done_o  = (state_q == S_DONE);
        bus.cpu_hold_o = (state_q == S_LOAD) || (state_q == S_DONE);
    end

    always_comb begin
        wptr_d = wptr_q;
        bcnt_d = bcnt_q;
        rem_d  = rem_q;
        asm_d  = asm_q;
        if (restart) begin
            wptr_d = '0;
            bcnt_d = '0;
            rem_d  = bus.ld_words_i;
            asm_d  = '0;
        end else if (take) begin
            bcnt_d = bcnt_q + 2'd1;
            case (bcnt_q)
                2'd0: asm_d[7:0]   = bus.ld_byte_i;
                2'd1: asm_d[15:8]  = bus.ld_byte_i;
                2'd2: asm_d[23:16] = bus.ld_byte_i;
                default: begin
                    wptr_d = wptr_q + 1'b1;
                    rem_d  = rem_q - (ADDR_W+1)'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            bcnt_q <= '0;
            rem_q  <= '0;
            asm_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            bcnt_q <= bcnt_d;
            rem_q  <= rem_d;
            asm_q  <= asm_d;
        end
    end

    // Array is deliberately outside the reset domain so programs survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= wr_data;
        end
    end

    always_comb begin
        bus.inst_o = bus.ce_i ? mem[bus.addr_i[ADDR_W+1:2]] : 32'h0;
    end
endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: reset, gapped load, fetch aliasing, zero-word load, restart, reset mid-load.
module tb_inst_mem;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    inst_mem_if #(.ADDR_W(ADDR_W)) bus ();

    inst_mem #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.ld_valid_i = 1'b1;
        bus.ld_byte_i  = b;
        while (bus.ld_ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (bus.ld_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL send_byte_ready: ld_ready_o=%b required 1 (byte %h)", bus.ld_ready_o, b);
        end
        tick();
        bus.ld_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.ld_start_i = 1'b1;
        bus.ld_words_i = 11'd2;
        tick();
        bus.ld_start_i = 1'b0;
        tests++;
        if (bus.cpu_hold_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_hold: cpu_hold_o=%b required 1", bus.cpu_hold_o);
        end
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.ld_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: ld_ready_o=%b required 0", bus.ld_ready_o);
        end
        tests++;
        if (bus.ld_done_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_done: ld_done_o=%b required 0", bus.ld_done_o);
        end
        tests++;
        if (bus.cpu_hold_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: cpu_hold_o=%b required 0", bus.cpu_hold_o);
        end
        tests++;
        if (bus.inst_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_inst: inst_o=%h required 00000000", bus.inst_o);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_two_word_load();
        logic [7:0] bytes [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        bus.ld_start_i = 1'b1;
        bus.ld_words_i = 11'd2;
        tick();
        bus.ld_start_i = 1'b0;
        tests++;
        if (bus.ld_ready_o !== 1'b1 || bus.cpu_hold_o !== 1'b1) begin
            fails++;
            $display("FAIL load_enter: ready=%b hold=%b required 1 1", bus.ld_ready_o, bus.cpu_hold_o);
        end
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            if (i < 7) begin
                tests++;
                if (bus.ld_done_o !== 1'b0 || bus.cpu_hold_o !== 1'b1) begin
                    fails++;
                    $display("FAIL load_mid_%0d: done=%b hold=%b required 0 1", i, bus.ld_done_o, bus.cpu_hold_o);
                end
            end
            if (i == 1 || i == 4) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    tests++;
                    if (bus.cpu_hold_o !== 1'b1 || bus.ld_done_o !== 1'b0) begin
                        fails++;
                        $display("FAIL load_gap_%0d: hold=%b done=%b required 1 0", i, bus.cpu_hold_o, bus.ld_done_o);
                    end
                end
            end
        end
        tests++;
        if (bus.ld_done_o !== 1'b1 || bus.cpu_hold_o !== 1'b1 || bus.ld_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL load_done: done=%b hold=%b ready=%b required 1 1 0",
                     bus.ld_done_o, bus.cpu_hold_o, bus.ld_ready_o);
        end
        tick();
        tests++;
        if (bus.ld_done_o !== 1'b0 || bus.cpu_hold_o !== 1'b0) begin
            fails++;
            $display("FAIL load_after: done=%b hold=%b required 0 0", bus.ld_done_o, bus.cpu_hold_o);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] addrs [5] = '{32'h4, 32'h0, 32'h1000, 32'h7, 32'h1004};
        logic [31:0] exp   [5] = '{32'h00200593, 32'h00100513, 32'h00100513, 32'h00200593, 32'h00200593};
        bus.ce_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.addr_i = addrs[i];
            #1;
            tests++;
            if (bus.inst_o !== exp[i]) begin
                fails++;
                $display("FAIL fetch_%h: inst_o=%h required %h", addrs[i], bus.inst_o, exp[i]);
            end
        end
        bus.ce_i = 1'b0;
        #1;
        tests++;
        if (bus.inst_o !== 32'h0) begin
            fails++;
            $display("FAIL fetch_ce0: inst_o=%h required 00000000", bus.inst_o);
        end
    endtask

    task automatic test_zero_word();
        bus.ld_start_i = 1'b1;
        bus.ld_words_i = 11'd0;
        tick();
        bus.ld_start_i = 1'b0;
        tests++;
        if (bus.ld_done_o !== 1'b1 || bus.ld_ready_o !== 1'b0 || bus.cpu_hold_o !== 1'b1) begin
            fails++;
            $display("FAIL zero_done: done=%b ready=%b hold=%b required 1 0 1",
                     bus.ld_done_o, bus.ld_ready_o, bus.cpu_hold_o);
        end
        tick();
        tests++;
        if (bus.ld_done_o !== 1'b0 || bus.ld_ready_o !== 1'b0 || bus.cpu_hold_o !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle: done=%b ready=%b hold=%b required 0 0 0",
                     bus.ld_done_o, bus.ld_ready_o, bus.cpu_hold_o);
        end
        bus.ce_i   = 1'b1;
        bus.addr_i = 32'h0;
        #1;
        tests++;
        if (bus.inst_o !== 32'h00100513) begin
            fails++;
            $display("FAIL zero_mem0: inst_o=%h required 00100513", bus.inst_o);
        end
        bus.ce_i = 1'b0;
    endtask

    task automatic test_restart();
        bus.ld_start_i = 1'b1;
        bus.ld_words_i = 11'd2;
        tick();
        bus.ld_start_i = 1'b0;
        send_byte(8'hAA);
        send_byte(8'hBB);
        bus.ld_start_i = 1'b1;
        bus.ld_words_i = 11'd1;
        tick();
        bus.ld_start_i = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        tests++;
        if (bus.ld_done_o !== 1'b0) begin
            fails++;
            $display("FAIL restart_early_done: ld_done_o=%b required 0", bus.ld_done_o);
        end
        send_byte(8'h04);
        tests++;
        if (bus.ld_done_o !== 1'b1) begin
            fails++;
            $display("FAIL restart_done: ld_done_o=%b required 1", bus.ld_done_o);
        end
        tick();
        bus.ce_i   = 1'b1;
        bus.addr_i = 32'h0;
        #1;
        tests++;
        if (bus.inst_o !== 32'h04030201) begin
            fails++;
            $display("FAIL restart_mem0: inst_o=%h required 04030201", bus.inst_o);
        end
        bus.addr_i = 32'h4;
        #1;
        tests++;
        if (bus.inst_o !== 32'h00200593) begin
            fails++;
            $display("FAIL restart_mem1: inst_o=%h required 00200593", bus.inst_o);
        end
        bus.ce_i = 1'b0;
    endtask

    task automatic test_reset_midload();
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus.ld_start_i = 1'b1;
        bus.ld_words_i = 11'd2;
        tick();
        bus.ld_start_i = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.cpu_hold_o !== 1'b0 || bus.ld_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_ctrl: hold=%b ready=%b required 0 0", bus.cpu_hold_o, bus.ld_ready_o);
        end
        tick();
        rst = 1'b0;
        bus.ld_valid_i = 1'b1;
        bus.ld_byte_i  = 8'hEE;
        tick();
        tick();
        bus.ld_valid_i = 1'b0;
        tests++;
        if (bus.ld_ready_o !== 1'b0 || bus.cpu_hold_o !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_idle: ready=%b hold=%b required 0 0", bus.ld_ready_o, bus.cpu_hold_o);
        end
        bus.ce_i   = 1'b1;
        bus.addr_i = 32'h0;
        #1;
        tests++;
        if (bus.inst_o !== 32'h44332211) begin
            fails++;
            $display("FAIL rstmid_mem0: inst_o=%h required 44332211", bus.inst_o);
        end
        bus.addr_i = 32'h4;
        #1;
        tests++;
        if (bus.inst_o !== 32'h00200593) begin
            fails++;
            $display("FAIL rstmid_mem1: inst_o=%h required 00200593", bus.inst_o);
        end
        bus.ce_i = 1'b0;
    endtask

    initial begin
        bus.ce_i       = 1'b0;
        bus.addr_i     = 32'h0;
        bus.ld_start_i = 1'b0;
        bus.ld_words_i = '0;
        bus.ld_valid_i = 1'b0;
        bus.ld_byte_i  = 8'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_two_word_load();
        test_fetch();
        test_zero_word();
        test_restart();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
